mold_hdr_tracker: RTL and testbench
===================================

# mold_hdr_tracker

Parametrised MoldUDP64 downstream-header decoder and sequence tracker for the ITCH feed path. It sits directly after the Ethernet/IP/UDP framing stage and consumes the raw packet beat stream. It extracts session ID, sequence number and message count at a configurable byte offset and bus width, converting them to host order. It also classifies each packet against the expected sequence: in order, gap, duplicate, heartbeat, end-of-session or short.

## Interface
Parameters:
- DATA_W, 64, beat width in bits; multiple of 8, min 32; B = DATA_W/8 byte lanes.
- HDR_OFFSET, 44, byte position of the first MoldUDP64 header byte, counted from byte 0 of the SOP beat.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  packet beat; lane j = data_in[8j+7:8j] = stream byte beat*B+j.
- in_valid  in  1  beat qualifier.
- in_sop  in  1  first beat of packet (qualified by in_valid).
- in_eop  in  1  last beat of packet (qualified by in_valid).
- session_id  out  80  header bytes H[0..9], H[0] in bits [79:72].
- seq_num  out  64  H[10..17], big-endian on wire, host order out.
- msg_count  out  16  H[18..19], big-endian on wire, host order out.
- hdr_valid  out  1  one-cycle pulse; header fields updated this cycle.
- heartbeat  out  1  pulse with hdr_valid when msg_count == 0.
- end_session  out  1  pulse with hdr_valid when msg_count == 16'hFFFF.
- short_pkt  out  1  one-cycle pulse; packet ended before header complete.
- session_chg  out  1  pulse with hdr_valid; session_id differs from previous packet.
- expected_seq  out  64  next expected sequence number.
- seq_gap  out  1  pulse with hdr_valid; seq_num > expected_seq.
- seq_dup  out  1  pulse with hdr_valid; seq_num < expected_seq.

## Operation
- Header byte H[k] = stream byte HDR_OFFSET+k, k = 0..19.
- Beat counter: cleared to 0 on a valid SOP beat, incremented per valid beat, saturates at its max; width covers ceil((HDR_OFFSET+20)/B)+1.
- Each valid beat: every lane whose stream position falls in [HDR_OFFSET, HDR_OFFSET+19] is written into a 20-byte shadow buffer. Published outputs never change mid-packet.
- States: IDLE -> CAPTURE on SOP; CAPTURE -> DONE when H[19] captured; DONE -> IDLE on EOP; any state -> CAPTURE on SOP.
  - SOP in CAPTURE or DONE silently abandons the old packet; no pulse.
  - Beats without a preceding SOP are ignored.
- EOP in CAPTURE before H[19] -> short_pkt; outputs unchanged; -> IDLE.
- Header completion (in the beat holding H[19]) publishes shadow to outputs and raises hdr_valid plus classification pulses. EOP on the same beat is legal.
- Sequence tracking, all arithmetic mod 2^64:
  - Sync state: after reset or on session_chg, no gap/dup; expected_seq := seq_num + msg_count.
  - Otherwise: gap if seq > expected; dup if seq < expected; neither if equal.
  - expected_seq := max(expected_seq, seq_num + msg_count) by unsigned compare.
  - Heartbeat (count 0): expected_seq := max(expected_seq, seq_num).
  - end_session: classified, but expected_seq unchanged.
- First packet after reset always raises session_chg.

## Timing
- Reset values: all outputs 0; state IDLE; sync pending.
- Latency: outputs and pulses registered, valid the cycle after the clock edge sampling the beat holding H[19].
- short_pkt: cycle after the EOP beat.
- All pulses exactly one cycle wide. No backpressure; one beat per cycle sustained.
- Reset asserted mid-packet: immediate clear; the partial packet is discarded.

## Configuration
- MOLD_SEQ_TRACK_EN defined: expected_seq, seq_gap and seq_dup behave as above.
- Not defined: tracking logic is removed; expected_seq, seq_gap and seq_dup are tied to 0.
- Header extraction, heartbeat, end_session, session_chg and short_pkt are unaffected by the macro.

## Test plan
- Defaults (DATA_W=64, HDR_OFFSET=44): 8-beat packet, session "SESSION001", seq 0x64, count 3 -> hdr_valid one cycle after beat 7; seq_num=0x64, msg_count=3, session_chg=1, expected_seq=0x67.
- Follow with seq 0x67 count 2 -> no gap/dup, expected_seq=0x69. Then seq 0x70 count 1 -> seq_gap=1, expected_seq=0x71. Then seq 0x69 count 1 -> seq_dup=1, expected_seq stays 0x71.
- Heartbeat seq 0x80 count 0 -> heartbeat=1, seq_gap=1, expected_seq=0x80. Then count 0xFFFF -> end_session=1, expected_seq unchanged.
- EOP on beat 6 -> short_pkt one cycle later; all fields hold prior values. SOP re-asserted at beat 4 of a packet -> new packet decoded correctly, no pulse for the abandoned one.
- DATA_W=128, HDR_OFFSET=42 -> header completes on beat 3 and decodes identically; rst pulled low on beat 2 -> all outputs 0 immediately, next packet raises session_chg.
- Build without MOLD_SEQ_TRACK_EN -> gap stimulus yields seq_gap=0, expected_seq=0; header fields still correct.

Source files
------------

// File: rtl/mold_hdr_tracker.sv
// mold_hdr_tracker: MoldUDP64 downstream-header decoder and sequence tracker.
// Captures the 20-byte header (session, sequence, count) at byte offset
// HDR_OFFSET of each packet, publishes it in host order and classifies the
// packet against the expected sequence number.
// Optional feature macro: MOLD_SEQ_TRACK_EN (sequence gap/dup tracking).
//
// Input handshake: a beat is consumed on every rising edge where in_valid is
// high; there is no ready, so the source may present one beat per cycle.
// in_sop/in_eop are meaningful only on valid beats.
module mold_hdr_tracker #(
  parameter int DATA_W     = 64,
  parameter int HDR_OFFSET = 44
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic [79:0]       session_id,
  output logic [63:0]       seq_num,
  output logic [15:0]       msg_count,
  output logic              hdr_valid,
  output logic              heartbeat,
  output logic              end_session,
  output logic              short_pkt,
  output logic              session_chg,
  output logic [63:0]       expected_seq,
  output logic              seq_gap,
  output logic              seq_dup
);

  localparam int B         = DATA_W / 8;
  localparam int HDR_LEN   = 20;
  localparam int HDR_BITS  = HDR_LEN * 8;
  localparam int LAST_BEAT = (HDR_OFFSET + HDR_LEN - 1) / B;
  localparam int CNT_MAX   = (HDR_OFFSET + HDR_LEN + B - 1) / B + 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     beat_cnt;
  logic [CNT_W-1:0]     cur_beat;
  logic [HDR_BITS-1:0]  shadow;
  logic [HDR_BITS-1:0]  shadow_nxt;
  logic                 sync_pend;
  logic                 active;
  logic                 complete;
  logic [79:0]          sid_n;
  logic [63:0]          seq_n;
  logic [15:0]          cnt_n;
  logic                 end_n;
  logic                 chg_n;
  logic                 unused_lanes;

  // Lanes outside the header window are intentionally dropped.
  assign unused_lanes = ^data_in;

  // Index of the beat on the bus: an SOP beat is always beat 0.
  assign cur_beat = in_sop ? '0 : beat_cnt;
  // A beat belongs to a packet being captured if it starts one or continues one.
  assign active   = in_valid && (in_sop || (state == CAPTURE));
  assign complete = active && (cur_beat == CNT_W'(LAST_BEAT));

  // Merge header lanes of the current beat into the shadow; H[0] sits at the top.
  always_comb begin
    shadow_nxt = shadow;
    for (int k = 0; k < HDR_LEN; k++) begin
      if (active && (cur_beat == CNT_W'((HDR_OFFSET + k) / B))) begin
        shadow_nxt[HDR_BITS-1-8*k -: 8] = data_in[8*((HDR_OFFSET + k) % B) +: 8];
      end
    end
  end

  assign sid_n = shadow_nxt[159:80];
  assign seq_n = shadow_nxt[79:16];
  assign cnt_n = shadow_nxt[15:0];
  assign end_n = (cnt_n == 16'hFFFF);
  // The first header after reset is always treated as a new session.
  assign chg_n = sync_pend || (sid_n != session_id);

  // Beat position within the packet, saturating once past the header.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
    end else if (in_valid) begin
      if (in_sop) begin
        beat_cnt <= CNT_W'(1);
      end else if (beat_cnt != CNT_W'(CNT_MAX)) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // Packet FSM, shadow capture, header publication and pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shadow      <= '0;
      sync_pend   <= 1'b1;
      session_id  <= '0;
      seq_num     <= '0;
      msg_count   <= '0;
      hdr_valid   <= 1'b0;
      heartbeat   <= 1'b0;
      end_session <= 1'b0;
      short_pkt   <= 1'b0;
      session_chg <= 1'b0;
    end else begin
      hdr_valid   <= 1'b0;
      heartbeat   <= 1'b0;
      end_session <= 1'b0;
      short_pkt   <= 1'b0;
      session_chg <= 1'b0;
      shadow      <= shadow_nxt;
      if (active) begin
        if (complete) begin
          state       <= in_eop ? IDLE : DONE;
          session_id  <= sid_n;
          seq_num     <= seq_n;
          msg_count   <= cnt_n;
          hdr_valid   <= 1'b1;
          heartbeat   <= (cnt_n == 16'h0000);
          end_session <= end_n;
          session_chg <= chg_n;
          sync_pend   <= 1'b0;
        end else if (in_eop) begin
          state     <= IDLE;
          short_pkt <= 1'b1;
        end else begin
          state <= CAPTURE;
        end
      end else if (in_valid && (state == DONE) && in_eop) begin
        state <= IDLE;
      end
    end
  end

`ifdef MOLD_SEQ_TRACK_EN
  logic [63:0] sum_n;
  logic [63:0] max_n;

  assign sum_n = seq_n + {48'd0, cnt_n};
  assign max_n = (sum_n > expected_seq) ? sum_n : expected_seq;

  // Sequence classification; a new session resynchronises without flagging.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      expected_seq <= '0;
      seq_gap      <= 1'b0;
      seq_dup      <= 1'b0;
    end else begin
      seq_gap <= 1'b0;
      seq_dup <= 1'b0;
      if (complete) begin
        if (chg_n) begin
          if (!end_n) expected_seq <= sum_n;
        end else begin
          seq_gap <= (seq_n > expected_seq);
          seq_dup <= (seq_n < expected_seq);
          if (!end_n) expected_seq <= max_n;
        end
      end
    end
  end
`else
  assign expected_seq = '0;
  assign seq_gap      = 1'b0;
  assign seq_dup      = 1'b0;
`endif

endmodule

// File: tb/tb_mold_hdr_tracker.sv
// Bench for mold_hdr_tracker: a default instance (64-bit, offset 44) and a
// wide instance (128-bit, offset 42). Expected headers are queued when the
// header-completing beat is driven and compared when hdr_valid appears.
module tb_mold_hdr_tracker;

`ifdef MOLD_SEQ_TRACK_EN
  localparam bit TRK = 1'b1;
`else
  localparam bit TRK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic         rst_a, valid_a, sop_a, eop_a;
  logic [63:0]  data_a;
  logic [79:0]  sid_a;
  logic [63:0]  seq_a, exp_a;
  logic [15:0]  cnt_a;
  logic         hv_a, hb_a, en_a, sh_a, chg_a, gap_a, dup_a;

  logic         rst_b, valid_b, sop_b, eop_b;
  logic [127:0] data_b;
  logic [79:0]  sid_b;
  logic [63:0]  seq_b, exp_b;
  logic [15:0]  cnt_b;
  logic         hv_b, hb_b, en_b, sh_b, chg_b, gap_b, dup_b;

  mold_hdr_tracker #(.DATA_W(64), .HDR_OFFSET(44)) dut_a (
    .clk(clk), .rst(rst_a), .data_in(data_a), .in_valid(valid_a),
    .in_sop(sop_a), .in_eop(eop_a), .session_id(sid_a), .seq_num(seq_a),
    .msg_count(cnt_a), .hdr_valid(hv_a), .heartbeat(hb_a),
    .end_session(en_a), .short_pkt(sh_a), .session_chg(chg_a),
    .expected_seq(exp_a), .seq_gap(gap_a), .seq_dup(dup_a)
  );

  mold_hdr_tracker #(.DATA_W(128), .HDR_OFFSET(42)) dut_b (
    .clk(clk), .rst(rst_b), .data_in(data_b), .in_valid(valid_b),
    .in_sop(sop_b), .in_eop(eop_b), .session_id(sid_b), .seq_num(seq_b),
    .msg_count(cnt_b), .hdr_valid(hv_b), .heartbeat(hb_b),
    .end_session(en_b), .short_pkt(sh_b), .session_chg(chg_b),
    .expected_seq(exp_b), .seq_gap(gap_b), .seq_dup(dup_b)
  );

  typedef struct {
    logic [79:0] sid;
    logic [63:0] seq;
    logic [15:0] cnt;
    bit hb, en, chg, gap, dup;
    logic [63:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [79:0] sid;
    logic [63:0] seq;
    logic [15:0] cnt;
    logic hb, en, chg, gap, dup;
    logic [63:0] exp;
  } rec_t;

  rec_t exp_q_a[$];
  rec_t exp_q_b[$];
  int   short_q_a[$];
  int   short_q_b[$];

  vec_t vt[8];
  localparam logic [79:0] S1 = "SESSION001";
  localparam logic [79:0] S2 = "SESSION002";

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic rec_t mk(input vec_t v, input int c);
    rec_t r;
    r.cyc = c;
    r.sid = v.sid; r.seq = v.seq; r.cnt = v.cnt;
    r.hb  = v.hb;  r.en  = v.en;  r.chg = v.chg;
    r.gap = v.gap & TRK;
    r.dup = v.dup & TRK;
    r.exp = TRK ? v.exp : 64'd0;
    return r;
  endfunction

  task automatic cmp_rec(input string t, input rec_t g, input rec_t e);
    chk({t, "_latency_cyc"}, g.cyc, e.cyc);
    chk({t, "_session_id"}, g.sid, e.sid);
    chk({t, "_seq_num"}, g.seq, e.seq);
    chk({t, "_msg_count"}, g.cnt, e.cnt);
    chk({t, "_flags_hb_end_chg"}, {g.hb, g.en, g.chg}, {e.hb, e.en, e.chg});
    chk({t, "_gap_dup"}, {g.gap, g.dup}, {e.gap, e.dup});
    chk({t, "_expected_seq"}, g.exp, e.exp);
  endtask

  // Monitor for the default instance.
  always @(negedge clk) begin : mon_a
    rec_t g;
    int   c;
    if (hv_a) begin
      g = {cyc, sid_a, seq_a, cnt_a, hb_a, en_a, chg_a, gap_a, dup_a, exp_a};
      if (exp_q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_hdr: got hdr_valid seq %0h, expected none", seq_a);
      end else begin
        cmp_rec("a", g, exp_q_a.pop_front());
      end
    end else begin
      chk("a_pulses_without_hdr", {hb_a, en_a, chg_a, gap_a, dup_a}, 5'd0);
    end
    if (sh_a) begin
      if (short_q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_short: got short_pkt at cycle %0d, expected none", cyc);
      end else begin
        c = short_q_a.pop_front();
        chk("a_short_cyc", cyc, c);
      end
    end
  end

  // Monitor for the wide instance.
  always @(negedge clk) begin : mon_b
    rec_t g;
    int   c;
    if (hv_b) begin
      g = {cyc, sid_b, seq_b, cnt_b, hb_b, en_b, chg_b, gap_b, dup_b, exp_b};
      if (exp_q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_hdr: got hdr_valid seq %0h, expected none", seq_b);
      end else begin
        cmp_rec("b", g, exp_q_b.pop_front());
      end
    end else begin
      chk("b_pulses_without_hdr", {hb_b, en_b, chg_b, gap_b, dup_b}, 5'd0);
    end
    if (sh_b) begin
      if (short_q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_short: got short_pkt at cycle %0d, expected none", cyc);
      end else begin
        c = short_q_b.pop_front();
        chk("b_short_cyc", cyc, c);
      end
    end
  end

  task automatic drive(input bit sel, input logic [127:0] d, input bit sop, input bit eop);
    if (sel) begin
      data_b = d; valid_b = 1'b1; sop_b = sop; eop_b = eop;
    end else begin
      data_a = d[63:0]; valid_a = 1'b1; sop_a = sop; eop_a = eop;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    valid_a = 1'b0; sop_a = 1'b0; eop_a = 1'b0;
    valid_b = 1'b0; sop_b = 1'b0; eop_b = 1'b0;
  endtask

  task automatic idle(input int n);
    go_idle();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send nbeats of a packet whose header sits at the instance's offset.
  task automatic send_pkt(input bit sel, input vec_t v, input int nbeats,
                          input bit with_eop, input bit push_hdr, input bit push_short);
    int bw, off, last, pos;
    logic [159:0] hv;
    logic [127:0] beat;
    logic [7:0]   bval;
    bw   = sel ? 16 : 8;
    off  = sel ? 42 : 44;
    last = (off + 19) / bw;
    hv   = {v.sid, v.seq, v.cnt};
    for (int b = 0; b < nbeats; b++) begin
      beat = '0;
      for (int j = 0; j < bw; j++) begin
        pos = b * bw + j;
        if (pos >= off && pos < off + 20) bval = hv[159 - 8 * (pos - off) -: 8];
        else bval = 8'($urandom_range(0, 255));
        beat[8 * j +: 8] = bval;
      end
      if (push_hdr && b == last) begin
        if (sel) exp_q_b.push_back(mk(v, cyc + 1));
        else exp_q_a.push_back(mk(v, cyc + 1));
      end
      if (push_short && b == nbeats - 1) begin
        if (sel) short_q_b.push_back(cyc + 1);
        else short_q_a.push_back(cyc + 1);
      end
      drive(sel, beat, b == 0, with_eop && (b == nbeats - 1));
    end
    go_idle();
  endtask

  task automatic check_zero(input bit sel, input string t);
    if (sel) begin
      chk({t, "_fields"}, {sid_b, seq_b, cnt_b}, '0);
      chk({t, "_expected_seq"}, exp_b, '0);
      chk({t, "_pulses"}, {hv_b, hb_b, en_b, sh_b, chg_b, gap_b, dup_b}, '0);
    end else begin
      chk({t, "_fields"}, {sid_a, seq_a, cnt_a}, '0);
      chk({t, "_expected_seq"}, exp_a, '0);
      chk({t, "_pulses"}, {hv_a, hb_a, en_a, sh_a, chg_a, gap_a, dup_a}, '0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t v;
    //        sid  seq                    cnt       hb en chg gap dup exp
    vt[0] = '{S1, 64'h64,                16'd3,    0, 0, 1,  0,  0, 64'h67};
    vt[1] = '{S1, 64'h67,                16'd2,    0, 0, 0,  0,  0, 64'h69};
    vt[2] = '{S1, 64'h70,                16'd1,    0, 0, 0,  1,  0, 64'h71};
    vt[3] = '{S1, 64'h69,                16'd1,    0, 0, 0,  0,  1, 64'h71};
    vt[4] = '{S1, 64'h80,                16'd0,    1, 0, 0,  1,  0, 64'h80};
    vt[5] = '{S1, 64'h80,                16'hFFFF, 0, 1, 0,  0,  0, 64'h80};
    vt[6] = '{S2, 64'h10,                16'd2,    0, 0, 1,  0,  0, 64'h12};
    vt[7] = '{S2, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2,  0, 0, 0,  1,  0, 64'h12};

    rst_a = 1'b0; rst_b = 1'b0;
    data_a = '0; data_b = '0;
    go_idle();
    #1;
    check_zero(0, "a_in_reset");
    check_zero(1, "b_in_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b1; rst_b = 1'b1;
    idle(2);
    check_zero(0, "a_after_reset");

    // Back-to-back 8-beat packets through the classification cases.
    for (int i = 0; i < 6; i++) send_pkt(0, vt[i], 8, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Beats with no preceding SOP must be ignored.
    v = '{S2, 64'h5, 16'd1, 0, 0, 0, 0, 0, 64'h0};
    for (int i = 0; i < 9; i++) drive(0, {64'd0, 64'($urandom())}, 1'b0, i == 8);
    idle(2);

    // Short packet: EOP on beat 6, before H[19]; outputs must hold.
    v = '{S2, 64'h90, 16'd1, 0, 0, 0, 0, 0, 64'h0};
    send_pkt(0, v, 7, 1'b1, 1'b0, 1'b1);
    idle(2);
    chk("a_hold_session_id", sid_a, S1);
    chk("a_hold_seq_num", seq_a, 64'h80);
    chk("a_hold_msg_count", cnt_a, 16'hFFFF);
    chk("a_hold_expected_seq", exp_a, TRK ? 64'h80 : 64'h0);

    // SOP re-asserted at beat 4 abandons the first packet silently.
    v = '{S2, 64'h99, 16'd7, 0, 0, 0, 0, 0, 64'h0};
    send_pkt(0, v, 4, 1'b0, 1'b0, 1'b0);
    v = '{S1, 64'h80, 16'd5, 0, 0, 0, 0, 0, 64'h85};
    send_pkt(0, v, 8, 1'b1, 1'b1, 1'b0);
    idle(1);

    // Session change resynchronises; then a wrapping sum keeps the max.
    for (int i = 6; i < 8; i++) send_pkt(0, vt[i], 8, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Wide instance: header completes on beat 3.
    send_pkt(1, vt[0], 4, 1'b1, 1'b1, 1'b0);
    idle(2);
    // Reset pulled low on beat 2 of the next packet clears everything at once.
    v = '{S1, 64'h300, 16'd4, 0, 0, 0, 0, 0, 64'h0};
    send_pkt(1, v, 2, 1'b0, 1'b0, 1'b0);
    data_b = {4{$urandom()}}; valid_b = 1'b1; sop_b = 1'b0; eop_b = 1'b0;
    rst_b = 1'b0;
    #1;
    check_zero(1, "b_mid_reset");
    @(posedge clk);
    #1;
    go_idle();
    rst_b = 1'b1;
    idle(2);
    v = '{S1, 64'h200, 16'd1, 0, 0, 1, 0, 0, 64'h201};
    send_pkt(1, v, 4, 1'b1, 1'b1, 1'b0);
    idle(4);

    chk("a_hdr_queue_empty", exp_q_a.size(), 0);
    chk("b_hdr_queue_empty", exp_q_b.size(), 0);
    chk("a_short_queue_empty", short_q_a.size(), 0);
    chk("b_short_queue_empty", short_q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
